game_sequencer: RTL and testbench
=================================

Name: game_sequencer

Overview:
- Top-level control FSM for the J.O.S.H. Jump game. Sequences the game datapath and the screen updater once per frame, in this order: menu, init, then per frame wait-tick, erase, physics update, draw, collision check.
- Owns the frame-rate divider, the gravity-flip request latch and the score counter.
- Sits between the board inputs (go/grav keys, already inverted to active-high) and the game datapath / update_screen blocks.

Parameters:
- FRAME_DIV, 833333, clk cycles per game frame (60 Hz at 50 MHz); legal range ≥4.
- FRAME_W, 20, frame counter width; must hold FRAME_DIV-1.
- SCORE_W, 8, score width.

Ports:
- clk  in  1  system clock (CLOCK_50).
- resetn  in  1  reset. Asynchronous, active-low.
- go  in  1  start/continue button, active-high level, already synchronous to clk.
- grav  in  1  gravity-flip button, active-high level, synchronous.
- endgame  in  1  datapath collision flag; only sampled in S_CHECK.
- erase_done  in  1  screen updater finished erasing (1-cycle pulse or level).
- draw_done  in  1  screen updater finished drawing.
- startgame  out  1  high in every in-game state (S_INIT through S_CHECK).
- init_pulse  out  1  1-cycle pulse; datapath reloads walls and dude position.
- erase_start  out  1  1-cycle pulse; starts the erase pass.
- update_en  out  1  1-cycle pulse; datapath advances one physics step.
- grav_flip  out  1  valid only with update_en; 1 means invert gravity this step.
- draw_start  out  1  1-cycle pulse; starts the draw pass.
- game_over  out  1  high in S_OVER and S_OVER_WAIT.
- score  out  SCORE_W  frames survived, saturating.
- frame_overrun  out  1  sticky; a frame tick arrived outside S_WAIT_FRAME.

Behaviour:
- Reset (async, resetn=0):
  - state = S_MENU.
  - All pulse outputs 0.
  - score = 0, frame counter = 0, grav pending = 0, grav_prev = 0, frame_overrun = 0.
- Outputs are Moore decodes of the registered state, except score and frame_overrun, which are registers.
- States and transitions:
  - S_MENU: go=1 -> S_MENU_WAIT.
  - S_MENU_WAIT: wait for go=0 (release) -> S_INIT.
  - S_INIT (1 cycle): init_pulse=1; score, frame counter, pending and frame_overrun cleared -> S_WAIT_FRAME.
  - S_WAIT_FRAME: frame_tick -> S_ERASE, else stay.
  - S_ERASE (1 cycle): erase_start=1 -> S_ERASE_WAIT.
  - S_ERASE_WAIT: erase_done -> S_UPDATE.
  - S_UPDATE (1 cycle): update_en=1, grav_flip=pending -> S_DRAW.
  - S_DRAW (1 cycle): draw_start=1 -> S_DRAW_WAIT.
  - S_DRAW_WAIT: draw_done -> S_CHECK.
  - S_CHECK (1 cycle):
    - endgame=1 -> S_OVER; score unchanged.
    - Else score <= score+1, saturating at all-ones -> S_WAIT_FRAME.
  - S_OVER: go=1 -> S_OVER_WAIT.
  - S_OVER_WAIT: go=0 -> S_MENU. score holds until the next S_INIT.
- Latency: frame_tick cycle -> erase_start high on the next cycle. A done pulse -> the following 1-cycle state on the next cycle.
- Frame counter:
  - Held at 0 in S_MENU, S_MENU_WAIT, S_OVER and S_OVER_WAIT; cleared in S_INIT.
  - Increments every cycle in S_WAIT_FRAME through S_CHECK.
  - At FRAME_DIV-1: frame_tick=1 and counter wraps to 0. First tick therefore occurs FRAME_DIV cycles after S_INIT.
- Overrun:
  - A frame_tick in any in-game state other than S_WAIT_FRAME sets frame_overrun.
  - That tick is dropped; the FSM waits for the next tick.
- Gravity:
  - rise = grav & ~grav_prev; grav_prev is updated every cycle.
  - rise in an in-game state sets pending. Multiple rises before S_UPDATE collapse to one flip.
  - S_UPDATE clears pending. A rise in the same cycle as S_UPDATE wins: pending stays 1 for the next frame, and the current grav_flip uses the old pending.
  - Rises in menu/over states are ignored.
- done inputs are ignored outside their wait states.
- endgame is ignored outside S_CHECK.
- Async reset asserted mid-frame returns to S_MENU immediately. No pulse may be emitted in the reset cycle.

Test Plan (FRAME_DIV=8 unless noted):
- Start: reset, go high 3 cycles then low -> S_MENU_WAIT, then S_INIT. init_pulse exactly 1 cycle; startgame rises with S_INIT; first erase_start 9 cycles after init_pulse.
- Frame loop: erase_done 2 cycles after erase_start, draw_done 3 cycles after draw_start, endgame=0 -> order erase_start, update_en, draw_start, each 1 cycle; score 0->1->2 over 2 frames; frame_overrun=0.
- Gravity: grav rising edges twice while in S_WAIT_FRAME -> exactly one update_en with grav_flip=1, next frame's grav_flip=0. Edge coincident with S_UPDATE -> grav_flip=1 on the following frame.
- Game over: endgame=1 during S_CHECK of frame 5 -> game_over=1, score=4, startgame=0; go press/release -> S_MENU; new start clears score to 0.
- Overrun: draw_done withheld 20 cycles -> frame_overrun=1 and sticky; loop resumes on next tick after draw_done.
- Saturation/reset: SCORE_W=2, 5 clean frames -> score stays 3. resetn pulsed low mid-S_ERASE_WAIT -> all outputs 0 asynchronously, state S_MENU.

Source files
------------

// File: rtl/game_sequencer.sv
// game_sequencer: top-level control FSM for the J.O.S.H. Jump game.
// Sequences menu -> init -> per-frame (wait tick, erase, update, draw, check).
// Owns the frame-rate divider, the gravity-flip request latch and the score.
// Handshake note: erase_start / draw_start are 1-cycle requests; the screen
// updater answers with erase_done / draw_done, which are only honoured in the
// matching *_WAIT state (a level or a pulse both work). All other inputs are
// levels sampled on the rising clock edge.
module game_sequencer #(
    parameter int FRAME_DIV = 833333,
    parameter int FRAME_W   = 20,
    parameter int SCORE_W   = 8
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               go,
    input  logic               grav,
    input  logic               endgame,
    input  logic               erase_done,
    input  logic               draw_done,
    output logic               startgame,
    output logic               init_pulse,
    output logic               erase_start,
    output logic               update_en,
    output logic               grav_flip,
    output logic               draw_start,
    output logic               game_over,
    output logic [SCORE_W-1:0] score,
    output logic               frame_overrun,
    output logic [3:0]         dbg_state
);

    typedef enum logic [3:0] {
        S_MENU, S_MENU_WAIT, S_INIT, S_WAIT_FRAME, S_ERASE, S_ERASE_WAIT,
        S_UPDATE, S_DRAW, S_DRAW_WAIT, S_CHECK, S_OVER, S_OVER_WAIT
    } state_t;

    localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(FRAME_DIV - 1);

    state_t               state_q, state_d;
    logic [FRAME_W-1:0]   frame_q, frame_d;
    logic [SCORE_W-1:0]   score_q, score_d;
    logic                 pending_q, pending_d;
    logic                 grav_prev_q;
    logic                 overrun_q, overrun_d;

    logic in_frame;     // states in which the frame counter runs
    logic frame_tick;
    logic grav_rise;

    assign in_frame   = (state_q inside {S_WAIT_FRAME, S_ERASE, S_ERASE_WAIT,
                                         S_UPDATE, S_DRAW, S_DRAW_WAIT, S_CHECK});
    assign frame_tick = in_frame && (frame_q == FRAME_LAST);
    assign grav_rise  = grav & ~grav_prev_q;

    // State and datapath registers, cleared asynchronously.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= S_MENU;
            frame_q     <= '0;
            score_q     <= '0;
            pending_q   <= 1'b0;
            grav_prev_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            frame_q     <= frame_d;
            score_q     <= score_d;
            pending_q   <= pending_d;
            grav_prev_q <= grav;
            overrun_q   <= overrun_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_MENU:       if (go)         state_d = S_MENU_WAIT;
            S_MENU_WAIT:  if (!go)        state_d = S_INIT;
            S_INIT:                       state_d = S_WAIT_FRAME;
            S_WAIT_FRAME: if (frame_tick) state_d = S_ERASE;
            S_ERASE:                      state_d = S_ERASE_WAIT;
            S_ERASE_WAIT: if (erase_done) state_d = S_UPDATE;
            S_UPDATE:                     state_d = S_DRAW;
            S_DRAW:                       state_d = S_DRAW_WAIT;
            S_DRAW_WAIT:  if (draw_done)  state_d = S_CHECK;
            S_CHECK:      state_d = endgame ? S_OVER : S_WAIT_FRAME;
            S_OVER:       if (go)         state_d = S_OVER_WAIT;
            S_OVER_WAIT:  if (!go)        state_d = S_MENU;
            default:                      state_d = S_MENU;
        endcase
    end

    // Moore output decode of the registered state.
    always_comb begin
        startgame   = (state_q == S_INIT) || in_frame;
        init_pulse  = (state_q == S_INIT);
        erase_start = (state_q == S_ERASE);
        update_en   = (state_q == S_UPDATE);
        grav_flip   = (state_q == S_UPDATE) && pending_q;
        draw_start  = (state_q == S_DRAW);
        game_over   = (state_q == S_OVER) || (state_q == S_OVER_WAIT);
    end

    // Frame divider, gravity latch, score and overrun flag.
    always_comb begin
        frame_d   = '0;
        score_d   = score_q;
        pending_d = pending_q;
        overrun_d = overrun_q;
        if (state_q == S_INIT) begin
            score_d   = '0;
            pending_d = 1'b0;
            overrun_d = 1'b0;
        end else if (in_frame) begin
            frame_d = frame_tick ? '0 : frame_q + FRAME_W'(1);
            // A tick outside the wait state is lost; remember that it happened.
            if (frame_tick && (state_q != S_WAIT_FRAME)) overrun_d = 1'b1;
            // A rise coinciding with the update is kept for the next frame.
            if (state_q == S_UPDATE) pending_d = grav_rise;
            else                     pending_d = pending_q | grav_rise;
            if ((state_q == S_CHECK) && !endgame && (score_q != '1))
                score_d = score_q + SCORE_W'(1);
        end
    end

    assign score         = score_q;
    assign frame_overrun = overrun_q;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_game_sequencer.sv
// tb_game_sequencer: randomized frame-level stimulus against a behavioural
// model of the game loop (tick schedule, score, gravity requests, overrun).
module tb_game_sequencer;

  localparam int FD   = 16;
  localparam int SW   = 3;
  localparam int SMAX = (1 << SW) - 1;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          go = 1'b0, grav = 1'b0, endgame = 1'b0;
  logic          erase_done = 1'b0, draw_done = 1'b0;
  logic          startgame, init_pulse, erase_start, update_en, grav_flip;
  logic          draw_start, game_over, frame_overrun;
  logic [SW-1:0] score;
  logic [3:0]    dbg_state;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // reference model state
  int init_cyc, wait_entry, m_score, rise_cnt;
  bit m_overrun, in_game;
  logic [SW-1:0] exp_q[$];

  game_sequencer #(.FRAME_DIV(FD), .FRAME_W(4), .SCORE_W(SW)) dut (
    .clk(clk), .resetn(resetn), .go(go), .grav(grav), .endgame(endgame),
    .erase_done(erase_done), .draw_done(draw_done),
    .startgame(startgame), .init_pulse(init_pulse), .erase_start(erase_start),
    .update_en(update_en), .grav_flip(grav_flip), .draw_start(draw_start),
    .game_over(game_over), .score(score), .frame_overrun(frame_overrun),
    .dbg_state(dbg_state)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog state=%0d", dbg_state);
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h cyc=%0d", tag, got, exp, cyc);
    end
  endtask

  // One clock: sample outputs at the falling edge, drop pulse inputs.
  task automatic cycle();
    @(negedge clk);
    cyc++;
    erase_done = 1'b0;
    draw_done  = 1'b0;
    endgame    = 1'b0;
    check_eq("pulse_exclusive",
             ($countones({init_pulse, erase_start, update_en, draw_start}) > 1), 0);
    check_eq("flip_only_with_update", grav_flip & ~update_en, 0);
  endtask

  task automatic set_grav(input logic v);
    if (v && !grav && in_game) rise_cnt++;
    grav = v;
  endtask

  task automatic start_game();
    int n;
    in_game = 0;
    set_grav(1'b1);          // press in the menu must be ignored
    cycle();
    set_grav(1'b0);
    go = 1'b1;
    repeat (3) cycle();
    check_eq("menu_no_start", startgame, 0);
    go = 1'b0;
    n = 0;
    do begin cycle(); n++; end while (!init_pulse && n < 10);
    check_eq("init_seen", init_pulse, 1);
    check_eq("start_with_init", startgame, 1);
    init_cyc   = cyc;
    wait_entry = cyc + 1;
    m_score    = 0;
    m_overrun  = 0;
    rise_cnt   = 0;
    in_game    = 1;
    cycle();
    check_eq("init_one_cycle", init_pulse, 0);
    check_eq("start_score", score, 0);
    check_eq("start_overrun", frame_overrun, 0);
  endtask

  task automatic play_frame(input int le, input int ld, input bit endg,
                            input int nrise, input bit grav_at_update);
    int e, c, t;
    logic [SW-1:0] exp_s;
    // next tick the FSM can accept: ticks fall every FD cycles after init
    e = wait_entry + 1;
    while (((e - init_cyc - 1) % FD) != 0) e++;
    t = 0;
    do begin
      cycle();
      t++;
      if (!erase_start) begin
        erase_done = ($urandom_range(0, 3) == 0);
        draw_done  = ($urandom_range(0, 3) == 0);
        endgame    = ($urandom_range(0, 3) == 0);
        if (nrise > 0 && !grav) begin set_grav(1'b1); nrise--; end
        else set_grav(1'b0);
      end
    end while (!erase_start && t < 2 * FD + 4);
    check_eq("erase_seen", erase_start, 1);
    check_eq("erase_cycle", cyc, e);
    e = cyc;
    set_grav(1'b0);
    repeat (le) begin
      cycle();
      check_eq("no_early_update", update_en, 0);
      draw_done = $urandom_range(0, 1);
      endgame   = $urandom_range(0, 1);
    end
    erase_done = 1'b1;
    cycle();
    check_eq("update_pulse", update_en, 1);
    check_eq("grav_flip", grav_flip, (rise_cnt > 0));
    rise_cnt = 0;
    set_grav(grav_at_update);
    cycle();
    check_eq("draw_pulse", draw_start, 1);
    check_eq("update_one_cycle", update_en, 0);
    set_grav(1'b0);
    repeat (ld) begin
      cycle();
      check_eq("no_extra_draw", draw_start, 0);
      erase_done = $urandom_range(0, 1);
      endgame    = $urandom_range(0, 1);
    end
    draw_done = 1'b1;
    cycle();
    c = cyc;
    endgame = endg;
    if (c >= e - 1 + FD) m_overrun = 1;
    if (!endg && m_score < SMAX) m_score++;
    exp_q.push_back(SW'(m_score));
    cycle();
    exp_s = exp_q.pop_front();
    check_eq("score", score, exp_s);
    check_eq("overrun", frame_overrun, m_overrun);
    check_eq("game_over", game_over, endg);
    check_eq("startgame_in_loop", startgame, !endg);
    wait_entry = c + 1;
    if (endg) in_game = 0;
  endtask

  task automatic finish_game();
    go = 1'b1;
    cycle();
    cycle();
    check_eq("over_wait_flag", game_over, 1);
    check_eq("over_no_start", startgame, 0);
    go = 1'b0;
    cycle();
    check_eq("back_to_menu", game_over, 0);
    check_eq("score_held", score, m_score);
  endtask

  task automatic reset_mid_frame();
    int t;
    t = 0;
    do begin cycle(); t++; end while (!erase_start && t < 2 * FD + 4);
    check_eq("rst_erase_seen", erase_start, 1);
    cycle();
    #2 resetn = 1'b0;
    #1;
    check_eq("rst_async_flags",
             {startgame, init_pulse, erase_start, update_en, grav_flip,
              draw_start, game_over, frame_overrun}, 8'h00);
    check_eq("rst_async_score", score, 0);
    cycle();
    resetn  = 1'b1;
    in_game = 0;
    cycle();
    check_eq("rst_menu_idle", {startgame, game_over}, 2'b00);
  endtask

  initial begin
    in_game = 0;
    repeat (2) @(negedge clk);
    check_eq("reset_flags",
             {startgame, init_pulse, erase_start, update_en, grav_flip,
              draw_start, game_over, frame_overrun}, 8'h00);
    check_eq("reset_score", score, 0);
    resetn = 1'b1;
    cycle();

    // first game: ordering, gravity collapse, coincident press, game over
    start_game();
    play_frame(2, 3, 0, 0, 0);
    play_frame(2, 3, 0, 2, 0);
    play_frame($urandom_range(1, 3), $urandom_range(1, 3), 0, 0, 1);
    play_frame($urandom_range(1, 3), $urandom_range(1, 3), 0, 0, 0);
    play_frame($urandom_range(1, 3), $urandom_range(1, 3), 1, 1, 0);
    check_eq("over_score", score, 4);
    finish_game();

    // second game: random frames, one overrun, saturation
    start_game();
    for (int i = 0; i < 10; i++)
      play_frame($urandom_range(1, 3), (i == 2) ? 20 : $urandom_range(1, 3), 0,
                 $urandom_range(0, 2), $urandom_range(0, 1));
    check_eq("score_saturated", score, SMAX);

    // asynchronous reset in the middle of a frame, then recovery
    reset_mid_frame();
    start_game();
    play_frame(1, 1, 0, 1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
